mvu_job_sched: RTL and testbench

Job scheduler in front of the MVU array. It accepts job descriptors from the APB-side control logic, buffers them in an in-order FIFO, and dispatches each job to its target MVU. Dispatch is a one-cycle start pulse with the descriptor on a broadcast bus. The block then tracks each MVU as busy until that MVU reports done. It sits between the APB register file and `mvutop`, replacing direct software pokes of per-MVU start bits.

---
 rtl/mvu_job_sched.sv | 134 +++++++++++++
 tb/tb_mvu_job_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : mvu_job_sched
// Purpose  : In-order job FIFO with per-MVU busy tracking and start dispatch.
//            Optional per-MVU watchdog enabled by MVU_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mvu_job_sched #(
    parameter int NMVU           = 8,
    parameter int DEPTH          = 4,
    parameter int CFG_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sched_en,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [$clog2(NMVU)-1:0]   job_mvu,
    input  logic [CFG_W-1:0]          job_cfg,
    output logic [NMVU-1:0]           mvu_start,
    output logic [CFG_W-1:0]          mvu_cfg,
    input  logic [NMVU-1:0]           mvu_done,
    output logic [NMVU-1:0]           mvu_busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [15:0]               jobs_done,
    input  logic                      err_clr,
    output logic [NMVU-1:0]           err_spurious,
    output logic [NMVU-1:0]           err_timeout
);

    localparam int c_MW = $clog2(NMVU);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [c_MW-1:0]  r_fifo_mvu [DEPTH];
    logic [CFG_W-1:0] r_fifo_cfg [DEPTH];
    logic [c_AW-1:0]  r_wptr, r_rptr;
    logic [c_CW-1:0]  r_count;
    logic [NMVU-1:0]  r_start, r_busy, r_spur;
    logic [CFG_W-1:0] r_cfg;
    logic [15:0]      r_jobs;

    logic             w_push, w_pop;
    logic [c_MW-1:0]  w_head_mvu;
    logic [NMVU-1:0]  w_head_bit, w_done_ok, w_spur_set, w_to, w_busy_nxt;
    logic [15:0]      w_ndone;

    // Reset forces not-ready so nothing is accepted while the FIFO is cleared.
    assign job_ready  = ~rst & (r_count != c_FULL);
    assign w_push     = job_valid & job_ready;
    assign w_head_mvu = r_fifo_mvu[r_rptr];
    assign w_pop      = (r_count != '0) & sched_en & ~r_busy[w_head_mvu];
    assign w_head_bit = w_pop ? (NMVU'(1) << w_head_mvu) : '0;
    assign w_done_ok  = mvu_done & r_busy;
    assign w_spur_set = mvu_done & ~r_busy;
    assign w_busy_nxt = (r_busy & ~mvu_done & ~w_to) | w_head_bit;

    always_comb begin
        w_ndone = '0;
        for (int i = 0; i < NMVU; i++) begin
            w_ndone = w_ndone + 16'(w_done_ok[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mvu[r_wptr] <= job_mvu;
            r_fifo_cfg[r_wptr] <= job_cfg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_start <= '0;
            r_busy  <= '0;
            r_spur  <= '0;
            r_cfg   <= '0;
            r_jobs  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
                r_cfg  <= r_fifo_cfg[r_rptr];
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            r_start <= w_head_bit;
            r_busy  <= w_busy_nxt;
            r_spur  <= (err_clr ? '0 : r_spur) | w_spur_set;
            r_jobs  <= r_jobs + w_ndone;
        end
    end

`ifdef MVU_SCHED_TIMEOUT_EN
    localparam int c_WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [NMVU-1:0] r_tmo;

    genvar gi;
    for (gi = 0; gi < NMVU; gi++) begin : g_wdog
        logic [c_WW-1:0] r_wdog;
        always_ff @(posedge clk) begin
            if (rst)                r_wdog <= '0;
            else if (w_head_bit[gi]) r_wdog <= '0;
            else if (r_busy[gi])    r_wdog <= r_wdog + c_WW'(1);
        end
        // A done arriving on the expiry cycle still counts as a completion.
        assign w_to[gi] = r_busy[gi] & ~mvu_done[gi] & (r_wdog == c_WW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) r_tmo <= '0;
        else     r_tmo <= (err_clr ? '0 : r_tmo) | w_to;
    end
    assign err_timeout = r_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_to         = '0;
    assign err_timeout  = '0;
`endif

    assign mvu_start    = r_start;
    assign mvu_cfg      = r_cfg;
    assign mvu_busy     = r_busy;
    assign fifo_count   = r_count;
    assign jobs_done    = r_jobs;
    assign err_spurious = r_spur;

endmodule
`default_nettype wire

// File: tb/tb_mvu_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_job_sched
// Purpose  : Directed plus randomized bench for mvu_job_sched against a
//            queue-based model (watchdog modelled under MVU_SCHED_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mvu_job_sched;

    localparam int c_DEPTH = 4;
    localparam int c_TMO   = 100;

    typedef struct {
        logic [2:0]  mvu;
        logic [31:0] cfg;
    } job_t;

    logic        clk = 1'b0;
    logic        rst, sched_en, job_valid, err_clr, job_ready;
    logic [2:0]  job_mvu;
    logic [31:0] job_cfg, mvu_cfg;
    logic [7:0]  mvu_start, mvu_done, mvu_busy, err_spurious, err_timeout;
    logic [2:0]  fifo_count;
    logic [15:0] jobs_done;

    int n_cmp = 0;
    int n_fail = 0;

    job_t        q[$];
    logic [7:0]  m_busy = '0, m_start = '0, m_spur = '0, m_to = '0;
    logic [31:0] m_cfg = '0;
    logic [15:0] m_jobs = '0;
    int          m_age[8];
    bit          m_valid = 0;

    mvu_job_sched #(
        .NMVU(8), .DEPTH(c_DEPTH), .CFG_W(32), .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_mvu(job_mvu), .job_cfg(job_cfg),
        .mvu_start(mvu_start), .mvu_cfg(mvu_cfg),
        .mvu_done(mvu_done), .mvu_busy(mvu_busy),
        .fifo_count(fifo_count), .jobs_done(jobs_done),
        .err_clr(err_clr), .err_spurious(err_spurious), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Model: state after each edge, from the inputs sampled at that edge.
    always @(posedge clk) begin
        logic [7:0] b_old, tob, popbit;
        bit         pop, rdy;
        job_t       h;
        m_valid = 1;
        if (rst) begin
            q.delete();
            m_busy = '0; m_start = '0; m_spur = '0; m_to = '0;
            m_cfg = '0; m_jobs = '0;
            for (int i = 0; i < 8; i++) m_age[i] = 0;
        end else begin
            rdy    = (q.size() != c_DEPTH);
            pop    = (q.size() != 0) && sched_en && !m_busy[q[0].mvu];
            b_old  = m_busy;
            tob    = '0;
`ifdef MVU_SCHED_TIMEOUT_EN
            for (int i = 0; i < 8; i++)
                tob[i] = b_old[i] && !mvu_done[i] && (m_age[i] == c_TMO);
`endif
            m_spur = (err_clr ? 8'h00 : m_spur) | (mvu_done & ~b_old);
            m_to   = (err_clr ? 8'h00 : m_to) | tob;
            m_jobs = m_jobs + 16'($countones(mvu_done & b_old));
            m_busy = b_old & ~mvu_done & ~tob;
            popbit = '0;
            if (pop) begin
                h      = q.pop_front();
                popbit = 8'd1 << h.mvu;
                m_cfg  = h.cfg;
                m_busy = m_busy | popbit;
            end
            m_start = popbit;
            for (int i = 0; i < 8; i++) begin
                if (popbit[i])     m_age[i] = 0;
                else if (b_old[i]) m_age[i] = m_age[i] + 1;
            end
            if (job_valid && rdy) q.push_back('{mvu: job_mvu, cfg: job_cfg});
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mvu_start", mvu_start, m_start);
            chk("mvu_cfg", mvu_cfg, m_cfg);
            chk("mvu_busy", mvu_busy, m_busy);
            chk("fifo_count", fifo_count, q.size());
            chk("jobs_done", jobs_done, m_jobs);
            chk("err_spurious", err_spurious, m_spur);
            chk("err_timeout", err_timeout, m_to);
            chk("job_ready", job_ready, (!rst && q.size() != c_DEPTH));
        end
    end

    task automatic drain();
        int n = 0;
        job_valid = 0;
        while ((q.size() != 0 || m_busy != 0) && n < 200) begin
            mvu_done = m_busy;
            step();
            n++;
        end
        mvu_done = '0;
        step();
        chk("drain_bound", (n < 200), 1);
    endtask

    initial begin
        int n;
        rst = 1; sched_en = 1; job_valid = 0; err_clr = 0;
        job_mvu = '0; job_cfg = '0; mvu_done = '0;
        step(); step();
        rst = 0;

        // Single job to MVU 3
        job_valid = 1; job_mvu = 3; job_cfg = 32'hDEADBEEF;
        step();
        job_valid = 0;
        at_neg(); chk("t1_count", fifo_count, 1); chk("t1_nostart", mvu_start, 0);
        step();
        at_neg(); chk("t1_start", mvu_start, 8'h08); chk("t1_cfg", mvu_cfg, 32'hDEADBEEF);
        chk("t1_busy", mvu_busy, 8'h08);
        step();
        at_neg(); chk("t1_start_once", mvu_start, 0); chk("t1_busy_hold", mvu_busy, 8'h08);
        repeat (6) step();
        mvu_done = 8'h08;
        step();
        mvu_done = '0;
        at_neg(); chk("t1_busy_clr", mvu_busy, 0); chk("t1_jobs", jobs_done, 1);

        // FIFO fill with MVU 5 held busy
        for (int k = 0; k < 5; k++) begin
            job_valid = 1; job_mvu = 5; job_cfg = 32'h500 + k;
            step();
        end
        job_cfg = 32'h505;
        at_neg(); chk("t2_full", fifo_count, 4); chk("t2_ready0", job_ready, 0);
        chk("t2_busy", mvu_busy, 8'h20);
        step();
        at_neg(); chk("t2_still_full", job_ready, 0);
        mvu_done = 8'h20;
        step();
        mvu_done = '0;
        n = 0;
        while (!job_ready && n < 20) begin step(); n++; end
        chk("t2_ready_bound", (n < 20), 1);
        step();
        job_valid = 0;
        drain();

        // Head-of-line blocking
        job_valid = 1; job_mvu = 1; job_cfg = 32'h11; step();
        job_cfg = 32'h12; step();
        job_mvu = 2; job_cfg = 32'h22; step();
        job_valid = 0;
        repeat (4) begin
            step();
            at_neg(); chk("t3_blocked", mvu_start, 0); chk("t3_count", fifo_count, 2);
        end
        mvu_done = 8'h02;
        step();
        mvu_done = '0;
        at_neg(); chk("t3_after_done", mvu_start, 0); chk("t3_busy0", mvu_busy, 0);
        step();
        at_neg(); chk("t3_start1", mvu_start, 8'h02); chk("t3_cfg1", mvu_cfg, 32'h12);
        step();
        at_neg(); chk("t3_start2", mvu_start, 8'h04); chk("t3_busy12", mvu_busy, 8'h06);
        drain();

        // Spurious done and clear
        mvu_done = 8'h40;
        step();
        mvu_done = '0;
        at_neg(); chk("t4_spur", err_spurious, 8'h40); chk("t4_jobs", jobs_done, 16'd10);
        err_clr = 1;
        step();
        err_clr = 0;
        at_neg(); chk("t4_clr", err_spurious, 0);

        // Reset mid-operation
        job_valid = 1; job_mvu = 0; job_cfg = 32'hA0; step();
        job_cfg = 32'hA1; step();
        job_cfg = 32'hA2; step();
        job_valid = 0;
        at_neg(); chk("t5_busy", mvu_busy, 8'h01); chk("t5_count", fifo_count, 2);
        rst = 1;
        at_neg(); chk("t5_ready_rst", job_ready, 0);
        step();
        rst = 0;
        at_neg(); chk("t5_busy_rst", mvu_busy, 0); chk("t5_count_rst", fifo_count, 0);
        chk("t5_cfg_rst", mvu_cfg, 0); chk("t5_jobs_rst", jobs_done, 0);
        chk("t5_ready_after", job_ready, 1);
        repeat (5) step();
        at_neg(); chk("t5_nostart", mvu_start, 0);
        mvu_done = 8'h01;
        step();
        mvu_done = '0;
        at_neg(); chk("t5_spur", err_spurious, 8'h01);
        err_clr = 1; step(); err_clr = 0;

`ifdef MVU_SCHED_TIMEOUT_EN
        // Watchdog expiry releases the queue
        job_valid = 1; job_mvu = 2; job_cfg = 32'h2A; step();
        job_cfg = 32'h2B; step();
        job_valid = 0;
        repeat (101) step();
        at_neg(); chk("t6_timeout", err_timeout, 8'h04); chk("t6_busy_clr", mvu_busy, 0);
        step();
        at_neg(); chk("t6_next_start", mvu_start, 8'h04); chk("t6_next_cfg", mvu_cfg, 32'h2B);
        drain();
        err_clr = 1; step(); err_clr = 0;
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] d;
            rst       = ($urandom_range(399) == 0);
            sched_en  = ($urandom_range(9) != 0);
            err_clr   = ($urandom_range(49) == 0);
            job_valid = ($urandom_range(1) == 1);
            job_mvu   = 3'($urandom_range(7));
            job_cfg   = $urandom;
            for (int i = 0; i < 8; i++)
                d[i] = m_busy[i] ? ($urandom_range(7) == 0) : ($urandom_range(499) == 0);
            mvu_done = d;
            step();
        end
        rst = 0; job_valid = 0; mvu_done = '0; err_clr = 0; sched_en = 1;
        step(); step();
        at_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
